// File: rtl/fifo_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_write_arbiter_if
// Description : Producer request/data/grant bundle plus the FIFO write port
//               shared by fifo_write_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_write_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int CW   = 7
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] data_in;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ack;
    logic               fifo_wr_en;
    logic [DW-1:0]      fifo_buf_in;
    logic [CW-1:0]      fifo_counter;
    logic               busy;

    modport master (
        output req, data_in, fifo_counter,
        input  gnt, ack, fifo_wr_en, fifo_buf_in, busy
    );

    modport slave (
        input  req, data_in, fifo_counter,
        output gnt, ack, fifo_wr_en, fifo_buf_in, busy
    );
endinterface
`default_nettype wire

// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_write_arbiter
// Description : Round-robin burst arbiter sharing one FIFO write port among
//               NREQ producers. Define FIFO_ARB_PRIO_EN to make requester 0
//               a fixed high-priority requester.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_write_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int DEPTH     = 64,
    parameter int CW        = 7,
    parameter int BURST_LEN = 4
) (
    input  logic                clk,
    input  logic                rst,
    fifo_write_arbiter_if.slave bus
);
    localparam int c_idx_w  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_beat_w = 5;
`ifdef FIFO_ARB_PRIO_EN
    localparam bit c_prio = 1'b1;
`else
    localparam bit c_prio = 1'b0;
`endif

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [NREQ-1:0]       r_gnt, w_gnt_nxt;
    logic [c_idx_w-1:0]    r_gnt_idx, w_gnt_idx_nxt;
    logic [c_idx_w-1:0]    r_last_gnt, w_last_nxt;
    logic [c_beat_w-1:0]   r_beat_cnt, w_beat_nxt;
    logic                  r_wr_en, w_wr_en_nxt;
    logic [DW-1:0]         r_buf_in, w_buf_nxt;

    logic [CW:0]           w_occ;
    logic                  w_space;
    logic                  w_req_g;
    logic                  w_ack_g;
    logic [DW-1:0]         w_sel_data;
    logic                  w_pick_vld;
    logic                  w_pick_upd;
    logic [c_idx_w-1:0]    w_pick;
    int                    w_scan;
    logic [c_idx_w-1:0]    w_scan_idx;

    // The registered write is not yet reflected in the counter, so count it.
    assign w_occ   = {1'b0, bus.fifo_counter} + {{CW{1'b0}}, r_wr_en};
    assign w_space = (w_occ < (CW+1)'(DEPTH));
    assign w_req_g = bus.req[r_gnt_idx];
    assign w_ack_g = (r_state == S_GRANT) && w_req_g && w_space;

    assign bus.ack         = r_gnt & {NREQ{w_ack_g}};
    assign bus.gnt         = r_gnt;
    assign bus.fifo_wr_en  = r_wr_en;
    assign bus.fifo_buf_in = r_buf_in;
    assign bus.busy        = (r_state == S_GRANT);

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_gnt_idx == c_idx_w'(i)) begin
                w_sel_data = bus.data_in[i*DW +: DW];
            end
        end
    end

    // Scan starts just after the last grant; in priority mode index 0 is
    // handled separately and never moves the round-robin pointer.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick_upd = 1'b1;
        w_pick     = '0;
        w_scan     = 0;
        w_scan_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_scan = int'(r_last_gnt) + k;
            if (w_scan >= NREQ) begin
                w_scan = w_scan - NREQ;
            end
            w_scan_idx = c_idx_w'(w_scan);
            if (!w_pick_vld && bus.req[w_scan_idx] && (!c_prio || w_scan != 0)) begin
                w_pick_vld = 1'b1;
                w_pick     = w_scan_idx;
            end
        end
        if (c_prio && bus.req[0]) begin
            w_pick_vld = 1'b1;
            w_pick     = '0;
            w_pick_upd = 1'b0;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_gnt_idx_nxt = r_gnt_idx;
        w_last_nxt    = r_last_gnt;
        w_beat_nxt    = r_beat_cnt;
        w_wr_en_nxt   = 1'b0;
        w_buf_nxt     = r_buf_in;
        case (r_state)
            S_IDLE: begin
                w_gnt_nxt = '0;
                if (w_pick_vld) begin
                    w_state_nxt   = S_GRANT;
                    w_gnt_nxt     = {{(NREQ-1){1'b0}}, 1'b1} << w_pick;
                    w_gnt_idx_nxt = w_pick;
                    w_beat_nxt    = '0;
                    if (w_pick_upd) begin
                        w_last_nxt = w_pick;
                    end
                end
            end
            S_GRANT: begin
                if (w_ack_g) begin
                    w_wr_en_nxt = 1'b1;
                    w_buf_nxt   = w_sel_data;
                    w_beat_nxt  = r_beat_cnt + 1'b1;
                end
                if (!w_req_g || (w_ack_g && r_beat_cnt == c_beat_w'(BURST_LEN-1))) begin
                    w_state_nxt = S_IDLE;
                    w_gnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_gnt      <= '0;
            r_gnt_idx  <= '0;
            r_last_gnt <= c_idx_w'(NREQ-1);
            r_beat_cnt <= '0;
            r_wr_en    <= 1'b0;
            r_buf_in   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_gnt_idx  <= w_gnt_idx_nxt;
            r_last_gnt <= w_last_nxt;
            r_beat_cnt <= w_beat_nxt;
            r_wr_en    <= w_wr_en_nxt;
            r_buf_in   <= w_buf_nxt;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_write_arbiter
// Description : Directed self-checking bench for fifo_write_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_write_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    fifo_write_arbiter_if #(.NREQ(4), .DW(8), .CW(7)) bus ();

    fifo_write_arbiter #(
        .NREQ(4), .DW(8), .DEPTH(64), .CW(7), .BURST_LEN(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        bus.req          = '0;
        bus.data_in      = '0;
        bus.fifo_counter = '0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.ack !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: gnt=%b busy=%b ack=%b want 0000/0/0000", bus.gnt, bus.busy, bus.ack);
        end
        n_checks++;
        if (bus.fifo_wr_en !== 1'b0 || bus.fifo_buf_in !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_wr: wr_en=%b buf=%h want 0/00", bus.fifo_wr_en, bus.fifo_buf_in);
        end
    endtask

    task automatic test_single_burst();
        do_reset();
        bus.req = 4'b0001;
        bus.data_in[7:0] = 8'hA0;
        #1;
        n_checks++;
        if (bus.ack !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_idle_ack: got %b want 0000", bus.ack);
        end
        cyc();
        n_checks++;
        if (bus.gnt !== 4'b0001 || bus.ack !== 4'b0001 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant: gnt=%b ack=%b busy=%b want 0001/0001/1", bus.gnt, bus.ack, bus.busy);
        end
        for (int b = 0; b < 4; b++) begin
            cyc();
            n_checks++;
            if (bus.fifo_wr_en !== 1'b1 || bus.fifo_buf_in !== 8'(8'hA0 + b)) begin
                n_fail++;
                $display("FAIL single_beat%0d: wr_en=%b buf=%h want 1/%h", b, bus.fifo_wr_en, bus.fifo_buf_in, 8'(8'hA0 + b));
            end
            if (b < 3) begin
                bus.data_in[7:0] = 8'(8'hA1 + b);
            end
        end
        n_checks++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_release: gnt=%b busy=%b want 0000/0", bus.gnt, bus.busy);
        end
        bus.req = 4'b0000;
        cyc();
        n_checks++;
        if (bus.fifo_wr_en !== 1'b0 || bus.gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_after: wr_en=%b gnt=%b want 0/0000", bus.fifo_wr_en, bus.gnt);
        end
    endtask

    task automatic test_round_robin();
        int         writes   = 0;
        int         idles    = 0;
        int         data_bad = 0;
        int         cur      = -1;
        int         order_code = 0;
        int         n_grants = 0;
        logic [3:0] prev     = 4'b0000;
        do_reset();
        bus.data_in = 32'h40302010;
        bus.req     = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            cyc();
            if (bus.fifo_wr_en === 1'b1) begin
                writes++;
                if (cur < 0 || bus.fifo_buf_in !== 8'((cur + 1) * 16)) data_bad++;
            end
            if (bus.gnt === 4'b0000) begin
                idles++;
            end else if (prev === 4'b0000) begin
                for (int i = 0; i < 4; i++) if (bus.gnt[i]) cur = i;
                order_code = order_code | (cur << (4 * n_grants));
                n_grants++;
            end
            prev = bus.gnt;
        end
        n_checks++;
        if (n_grants != 4 || order_code != 32'h3210) begin
            n_fail++;
            $display("FAIL rr_order: grants=%0d code=%h want 4/3210", n_grants, order_code);
        end
        n_checks++;
        if (writes != 16 || idles != 4) begin
            n_fail++;
            $display("FAIL rr_throughput: writes=%0d idles=%0d want 16/4", writes, idles);
        end
        n_checks++;
        if (data_bad != 0) begin
            n_fail++;
            $display("FAIL rr_data: bad=%0d want 0", data_bad);
        end
        cyc();
        n_checks++;
        if (bus.gnt !== 4'b0001 || bus.fifo_wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_wrap: gnt=%b wr_en=%b want 0001/0", bus.gnt, bus.fifo_wr_en);
        end
        bus.req = 4'b0000;
    endtask

    task automatic test_full_fifo();
        do_reset();
        bus.fifo_counter = 7'd63;
        bus.data_in[15:8] = 8'h5A;
        bus.req = 4'b0010;
        cyc();
        n_checks++;
        if (bus.gnt !== 4'b0010 || bus.ack !== 4'b0010) begin
            n_fail++;
            $display("FAIL full_first_ack: gnt=%b ack=%b want 0010/0010", bus.gnt, bus.ack);
        end
        cyc();
        n_checks++;
        if (bus.fifo_wr_en !== 1'b1 || bus.fifo_buf_in !== 8'h5A || bus.ack !== 4'b0000) begin
            n_fail++;
            $display("FAIL full_inflight: wr_en=%b buf=%h ack=%b want 1/5a/0000", bus.fifo_wr_en, bus.fifo_buf_in, bus.ack);
        end
        bus.fifo_counter = 7'd64;
        for (int c = 0; c < 4; c++) begin
            cyc();
            n_checks++;
            if (bus.ack !== 4'b0000 || bus.gnt !== 4'b0010 || bus.fifo_wr_en !== 1'b0) begin
                n_fail++;
                $display("FAIL full_hold%0d: ack=%b gnt=%b wr_en=%b want 0000/0010/0", c, bus.ack, bus.gnt, bus.fifo_wr_en);
            end
        end
        bus.fifo_counter = 7'd63;
        #1;
        n_checks++;
        if (bus.ack !== 4'b0010) begin
            n_fail++;
            $display("FAIL full_resume_ack: got %b want 0010", bus.ack);
        end
        cyc();
        n_checks++;
        if (bus.fifo_wr_en !== 1'b1) begin
            n_fail++;
            $display("FAIL full_resume_wr: got %b want 1", bus.fifo_wr_en);
        end
        bus.req = 4'b0000;
        bus.fifo_counter = 7'd0;
        cyc();
        n_checks++;
        if (bus.gnt !== 4'b0000 || bus.fifo_wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL full_release: gnt=%b wr_en=%b want 0000/0", bus.gnt, bus.fifo_wr_en);
        end
    endtask

    task automatic test_early_release();
        do_reset();
        bus.data_in = 32'hD0C00000;
        bus.req     = 4'b1100;
        cyc();
        n_checks++;
        if (bus.gnt !== 4'b0100) begin
            n_fail++;
            $display("FAIL early_grant: got %b want 0100", bus.gnt);
        end
        cyc();
        bus.data_in[23:16] = 8'hC1;
        cyc();
        n_checks++;
        if (bus.fifo_wr_en !== 1'b1 || bus.fifo_buf_in !== 8'hC1) begin
            n_fail++;
            $display("FAIL early_beat2: wr_en=%b buf=%h want 1/c1", bus.fifo_wr_en, bus.fifo_buf_in);
        end
        bus.req = 4'b1000;
        #1;
        n_checks++;
        if (bus.ack !== 4'b0000 || bus.gnt !== 4'b0100) begin
            n_fail++;
            $display("FAIL early_noack: ack=%b gnt=%b want 0000/0100", bus.ack, bus.gnt);
        end
        cyc();
        n_checks++;
        if (bus.gnt !== 4'b0000 || bus.fifo_wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL early_release: gnt=%b wr_en=%b want 0000/0", bus.gnt, bus.fifo_wr_en);
        end
        cyc();
        n_checks++;
        if (bus.gnt !== 4'b1000) begin
            n_fail++;
            $display("FAIL early_next: got %b want 1000", bus.gnt);
        end
        bus.req = 4'b0000;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        bus.data_in[7:0] = 8'h55;
        bus.req = 4'b0001;
        cyc();
        cyc();
        cyc();
        n_checks++;
        if (bus.ack !== 4'b0001 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_beat3: ack=%b busy=%b want 0001/1", bus.ack, bus.busy);
        end
        rst     = 1'b1;
        bus.req = 4'b1000;
        cyc();
        n_checks++;
        if (bus.gnt !== 4'b0000 || bus.fifo_wr_en !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_clear: gnt=%b wr_en=%b busy=%b want 0000/0/0", bus.gnt, bus.fifo_wr_en, bus.busy);
        end
        rst = 1'b0;
        cyc();
        n_checks++;
        if (bus.gnt !== 4'b1000) begin
            n_fail++;
            $display("FAIL midrst_regrant: got %b want 1000", bus.gnt);
        end
        bus.req = 4'b0000;
    endtask

`ifdef FIFO_ARB_PRIO_EN
    task automatic test_prio();
        do_reset();
        bus.req = 4'b0110;
        cyc();
        n_checks++;
        if (bus.gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL prio_first: got %b want 0010", bus.gnt);
        end
        bus.req = 4'b0111;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            if (c == 5) begin
                n_checks++;
                if (bus.gnt !== 4'b0001) begin
                    n_fail++;
                    $display("FAIL prio_req0: got %b want 0001", bus.gnt);
                end
            end
            if (c == 9) bus.req = 4'b0110;
            if (c == 10) begin
                n_checks++;
                if (bus.gnt !== 4'b0100) begin
                    n_fail++;
                    $display("FAIL prio_rr: got %b want 0100", bus.gnt);
                end
            end
        end
        bus.req = 4'b0000;
    endtask
`endif

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_full_fifo();
        test_early_release();
        test_reset_mid_burst();
`ifdef FIFO_ARB_PRIO_EN
        test_prio();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
